sub_bytes_pipe: RTL and testbench

SUB_BYTES_PIPE -- requirements
Module: sub_bytes_pipe

---
 rtl/sub_bytes_pipe.sv | 180 ++++++++++++++++++
 tb/tb_sub_bytes_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: two-stage AES SubBytes pipeline over LANES independent byte lanes
// with a valid/ready handshake on both sides.
//
// Optional feature: define SUB_BYTES_INV_EN to build the inverse S-box tables.
// Then in_inv=1 selects the inverse substitution for that word. Without the
// macro, in_inv is accepted but ignored. Every word then gets the forward
// S-box and out_inv reads 0.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   in_valid/in_ready               input handshake (in_ready is low during rst)
//   in_data[8*LANES-1:0]            input bytes, lane k at bits 8k+7:8k
//   in_inv, in_tag[TAG_W-1:0]       per-word mode and sideband tag
//   out_valid/out_ready             output handshake
//   out_data, out_inv, out_tag      substituted word, applied mode and tag (from S2)
//   busy                            any stage holds a word
module sub_bytes_pipe #(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int DATA_W = 8 * LANES;

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef SUB_BYTES_INV_EN
    localparam bit INV_EN = 1'b1;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sub(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction
`else
    localparam bit INV_EN = 1'b0;
`endif

    function automatic logic [7:0] fwd_sub(input logic [7:0] b);
        return FWD_SBOX[b];
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic              s1_inv_q,   s1_inv_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;
    logic              s2_inv_q,   s2_inv_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
    logic              in_fire;
    logic              s2_load;
    logic [DATA_W-1:0] sub_data;

    // Lane lookup between S1 and S2
    always_comb begin
        sub_data = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef SUB_BYTES_INV_EN
            sub_data[8*k +: 8] = s1_inv_q ? inv_sub(s1_data_q[8*k +: 8])
                                          : fwd_sub(s1_data_q[8*k +: 8]);
`else
            sub_data[8*k +: 8] = fwd_sub(s1_data_q[8*k +: 8]);
`endif
        end
    end

    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        // in_ready is forced low during reset so nothing is accepted that cycle.
        in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
        in_fire  = in_valid && in_ready;

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_inv_d   = s1_inv_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_inv_d   = s2_inv_q;
        s2_tag_d   = s2_tag_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            // Without the inverse tables the captured mode is always forward.
            s1_inv_d   = in_inv && INV_EN;
            s1_tag_d   = in_tag;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = sub_data;
            s2_inv_d   = s1_inv_q;
            s2_tag_d   = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Stage S1: input capture (payload needs no reset; it is qualified by valid)
    always_ff @(posedge clk) begin
        s1_data_q <= s1_data_d;
        s1_inv_q  <= s1_inv_d;
        s1_tag_q  <= s1_tag_d;
    end

    // Stage S2: substituted word, drives the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_inv_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_inv_q   <= s2_inv_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    // out_valid is masked during reset so no word can transfer on that cycle.
    assign out_valid = s2_valid_q && !rst;
    assign out_data  = s2_data_q;
    assign out_inv   = s2_inv_q;
    assign out_tag   = s2_tag_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: a LANES=4 instance for handshake, latency, stall
// and reset behaviour, and a LANES=16 instance for the full-table sweep.
// The reference S-box is derived from GF(2^8) inversion plus the affine map.
`timescale 1ns/1ps
module tb_sub_bytes_pipe;
`ifdef SUB_BYTES_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    typedef struct packed {
        logic [127:0] data;
        logic         inv;
        logic [3:0]   tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv, a_busy;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_in_tag, a_out_tag;

    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv, b_busy;
    logic [127:0] b_in_data, b_out_data;
    logic [3:0]   b_in_tag, b_out_tag;

    sub_bytes_pipe #(.LANES(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_inv(a_in_inv), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_inv(a_out_inv), .out_tag(a_out_tag), .busy(a_busy)
    );

    sub_bytes_pipe #(.LANES(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_inv(b_in_inv), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_inv(b_out_inv), .out_tag(b_out_tag), .busy(b_busy)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] sbox_m [256];
    logic [7:0] isbox_m [256];
    exp_t qa[$];
    exp_t qb[$];
    int a_out_count = 0;
    int b_out_count = 0;
    logic s_in_ready, s_out_valid, s_busy, s_in_fire;
    logic hold_pend = 1'b0;
    logic [36:0] hold_word;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] w = {b, b};
        return w[15-n -: 8];
    endfunction

    task automatic build_model();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_m[x] = s;
            isbox_m[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_word(input logic [127:0] d, input int lanes, input logic inv);
        logic [127:0] r = '0;
        for (int k = 0; k < lanes; k++)
            r[8*k +: 8] = (inv && INV_EN) ? isbox_m[d[8*k +: 8]] : sbox_m[d[8*k +: 8]];
        return r;
    endfunction

    // One clock of the 4-lane instance: sample, score, then advance to posedge+1.
    task automatic cyc_a();
        exp_t e;
        #1;
        s_in_ready  = a_in_ready;
        s_out_valid = a_out_valid;
        s_busy      = a_busy;
        s_in_fire   = a_in_valid && a_in_ready;
        if (rst) begin
            check("in_ready_during_rst", 128'(a_in_ready), 128'(0));
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 128'(a_out_valid), 128'(1));
                check("hold_word", 128'({a_out_tag, a_out_inv, a_out_data}), 128'(hold_word));
            end
            hold_pend = a_out_valid && !a_out_ready;
            hold_word = {a_out_tag, a_out_inv, a_out_data};
            if (a_out_valid && a_out_ready) begin
                a_out_count++;
                if (qa.size() == 0) begin
                    check("a_out_unexpected", 128'(a_out_valid), 128'(0));
                end else begin
                    e = qa.pop_front();
                    check("a_data", 128'(a_out_data), e.data);
                    check("a_inv", 128'(a_out_inv), 128'(e.inv));
                    check("a_tag", 128'(a_out_tag), 128'(e.tag));
                end
            end
            if (s_in_fire) begin
                e.data = model_word(128'(a_in_data), 4, a_in_inv);
                e.inv  = a_in_inv && INV_EN;
                e.tag  = a_in_tag;
                qa.push_back(e);
            end
        end
        @(posedge clk);
        if (rst) qa.delete();
        #1;
    endtask

    task automatic cyc_b();
        exp_t e;
        #1;
        if (b_out_valid && b_out_ready) begin
            b_out_count++;
            if (qb.size() == 0) begin
                check("b_out_unexpected", 128'(b_out_valid), 128'(0));
            end else begin
                e = qb.pop_front();
                check("b_data", b_out_data, e.data);
                check("b_inv", 128'(b_out_inv), 128'(e.inv));
                check("b_tag", 128'(b_out_tag), 128'(e.tag));
            end
        end
        if (b_in_valid) check("b_in_ready", 128'(b_in_ready), 128'(1));
        if (b_in_valid && b_in_ready) begin
            e.data = model_word(b_in_data, 16, b_in_inv);
            e.inv  = b_in_inv && INV_EN;
            e.tag  = b_in_tag;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    int idx;
    int deliv0;
    logic inv_t;
    logic [31:0] wq [3];
    logic [7:0] v;

    initial begin
        build_model();
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_inv = 1'b0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_inv = 1'b0; b_in_tag = '0; b_out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset state
        cyc_a(); cyc_a();
        rst = 1'b0;
        cyc_a();
        check("rst_out_valid", 128'(s_out_valid), 128'(0));
        check("rst_busy", 128'(s_busy), 128'(0));
        check("rst_in_ready", 128'(s_in_ready), 128'(1));
        check("rst_out_word", 128'({a_out_tag, a_out_inv, a_out_data}), 128'(0));

        // Forward latency and known value
        a_in_valid = 1'b1; a_in_data = 32'hFF53_0100; a_in_inv = 1'b0; a_in_tag = 4'h3;
        cyc_a();
        check("lat_accept", 128'(s_in_fire), 128'(1));
        a_in_valid = 1'b0;
        cyc_a();
        check("lat_cycle1_valid", 128'(s_out_valid), 128'(0));
        cyc_a();
        check("lat_cycle2_valid", 128'(s_out_valid), 128'(1));
        check("fwd_known_data", 128'(a_out_data), 128'(32'h16ED_7C63));
        check("fwd_known_tag", 128'(a_out_tag), 128'(4'h3));

        // Inverse request
        a_in_valid = 1'b1; a_in_data = 32'h16ED_7C63; a_in_inv = 1'b1; a_in_tag = 4'h5;
        cyc_a();
        a_in_valid = 1'b0;
        cyc_a(); cyc_a();
        check("inv_known_valid", 128'(s_out_valid), 128'(1));
        check("inv_known_data", 128'(a_out_data), INV_EN ? 128'(32'hFF53_0100) : 128'(32'h4755_10FB));
        check("inv_known_inv", 128'(a_out_inv), 128'(INV_EN));

        // 16 back-to-back words
        for (int i = 0; i < 20; i++) begin
            a_in_valid = (i < 16);
            a_in_data  = $urandom;
            a_in_inv   = 1'(i & 1);
            a_in_tag   = 4'(i);
            cyc_a();
            if (i < 16) check("b2b_in_ready", 128'(s_in_ready), 128'(1));
            check("b2b_out_valid", 128'(s_out_valid), 128'(i >= 2 && i < 18));
        end
        a_in_valid = 1'b0;
        check("b2b_drained", 128'(qa.size()), 128'(0));

        // Stall with three offered words
        for (int i = 0; i < 3; i++) wq[i] = $urandom;
        a_out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            a_in_valid = (idx < 3);
            a_in_data  = wq[idx < 3 ? idx : 0];
            a_in_inv   = 1'(idx & 1);
            a_in_tag   = 4'(idx + 8);
            cyc_a();
            if (s_in_fire) idx++;
        end
        check("stall_accepted", 128'(idx), 128'(2));
        check("stall_in_ready", 128'(s_in_ready), 128'(0));
        deliv0 = a_out_count;
        a_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            a_in_valid = (idx < 3);
            a_in_data  = wq[idx < 3 ? idx : 0];
            a_in_inv   = 1'(idx & 1);
            a_in_tag   = 4'(idx + 8);
            cyc_a();
            if (s_in_fire) idx++;
        end
        a_in_valid = 1'b0;
        check("stall_delivered", 128'(a_out_count - deliv0), 128'(3));
        check("stall_drained", 128'(qa.size()), 128'(0));

        // Reset with both stages full
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = $urandom; cyc_a();
        a_in_data = $urandom; cyc_a();
        a_in_valid = 1'b0; cyc_a();
        check("full_out_valid", 128'(s_out_valid), 128'(1));
        check("full_busy", 128'(s_busy), 128'(1));
        check("full_in_ready", 128'(s_in_ready), 128'(0));
        rst = 1'b1; a_in_valid = 1'b1; a_in_data = $urandom; a_out_ready = 1'b1;
        cyc_a();
        check("rst_no_out_transfer", 128'(s_out_valid), 128'(0));
        rst = 1'b0; a_in_valid = 1'b0;
        cyc_a();
        check("midrst_out_valid", 128'(s_out_valid), 128'(0));
        check("midrst_busy", 128'(s_busy), 128'(0));
        for (int c = 0; c < 6; c++) begin
            cyc_a();
            check("midrst_no_stale", 128'(s_out_valid), 128'(0));
        end

        // Random traffic, mode toggling on every accepted word
        inv_t = 1'b0;
        for (int c = 0; c < 300; c++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = $urandom;
            a_in_inv    = inv_t;
            a_in_tag    = 4'($urandom_range(0, 15));
            a_out_ready = ($urandom_range(0, 2) != 0);
            cyc_a();
            if (s_in_fire) inv_t = ~inv_t;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) cyc_a();
        check("rand_drained", 128'(qa.size()), 128'(0));
        check("rand_idle_busy", 128'(s_busy), 128'(0));

        // 16-lane sweep: forward over all byte values, then inverse of forward values
        for (int i = 0; i < 512; i++) begin
            b_in_valid = 1'b1;
            for (int k = 0; k < 16; k++) begin
                v = 8'((i % 256) + 16 * k);
                if (i >= 256) v = sbox_m[v];
                b_in_data[8*k +: 8] = v;
            end
            b_in_inv = (i >= 256);
            b_in_tag = 4'(i);
            cyc_b();
        end
        b_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cyc_b();
        check("sweep_count", 128'(b_out_count), 128'(512));
        check("sweep_drained", 128'(qb.size()), 128'(0));
        check("sweep_busy", 128'(b_busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
